ixc_phase_divider: RTL
======================

// Module: ixc_phase_divider
// PURPOSE
//  Consumes the emulator master clock phi1 and derives a programmable divided clock
//  (clk_div) plus a one-cycle period strobe (clk_en) for the DUT-partition clock tree.
//  The divide ratio changes at run time through a req/ack handshake.
//  A new ratio only takes effect at a period boundary, so clk_div never glitches.
//  A period counter lets the testbench correlate emulator time with divided-clock cycles.
// PARAMETERS
//  CNT_W        8   width of the divide ratio and of the phase counter
//  DEFAULT_DIV  4   divide ratio loaded at reset; must be in 2..2^CNT_W-1
//  CYC_W        32  width of the completed-period counter
// PORTS
//  phi1     in   1      clock (master clock output); all logic on posedge phi1
//  rst_n    in   1      asynchronous, active-low reset
//  run      in   1      1 = generate divided clock; 0 = stop at next period boundary
//  div_req  in   1      request to load div_val (sampled every cycle, level not edge)
//  div_val  in   CNT_W  requested divide ratio N; valid range 2..2^CNT_W-1
//  div_ack  out  1      one-cycle pulse: requested ratio is now in effect
//  div_err  out  1      one-cycle pulse: request rejected (div_val < 2)
//  clk_en   out  1      one-cycle strobe on the phi1 cycle where clk_div rises
//  clk_div  out  1      divided clock; high for ceil(N/2) phi1 cycles, low for floor(N/2)
//  phase    out  CNT_W  position within the current period, 0..N-1
//  cycles   out  CYC_W  count of completed periods; wraps modulo 2^CYC_W
// BEHAVIOUR
//  Reset values (asynchronous on rst_n=0)
//   - state=IDLE, N=DEFAULT_DIV, pending cleared.
//   - All outputs 0: div_ack, div_err, clk_en, clk_div, phase, cycles.
//   - Reset mid-period truncates the period immediately; no pending ack is issued.
//  All outputs are registered and update on posedge phi1.
//  States: IDLE, RUN, PEND (run with a ratio change pending).
//  IDLE
//   - clk_div=0, phase=0.
//   - run=1 -> RUN; on the same edge phase<=0, clk_div<=1, clk_en<=1.
//     The first rising edge appears 1 cycle after run is sampled.
//  RUN / PEND, each edge
//   - phase!=N-1 -> phase<=phase+1, clk_en<=0, clk_div<=(phase+1 < ceil(N/2)).
//   - phase==N-1 (boundary) -> cycles<=cycles+1, phase<=0.
//     - If run=1: clk_div<=1, clk_en<=1.
//     - If run=0: clk_div<=0, clk_en<=0, go IDLE. There is no truncated period.
//   - A run deassert that is reasserted before the boundary has no effect.
//  Ratio change
//   - div_req=1 with div_val<2 in any state -> div_err<=1 next edge; nothing else changes.
//   - Valid div_req in IDLE -> N<=div_val, div_ack<=1 on the next edge.
//   - Valid div_req in RUN -> latch pending value, go PEND.
//   - PEND at the boundary -> N<=pending, div_ack<=1 (same edge as clk_en), go RUN,
//     or go IDLE if run=0. The new period uses the new N.
//   - A valid req in PEND overwrites the pending value. Only one ack is issued, at the
//     boundary, for the last value.
//   - A req on the boundary edge itself is latched for the next boundary. The value
//     applied at this boundary is the one pending before that edge.
//  Arithmetic
//   - phase compare is unsigned CNT_W; ceil(N/2) = (N+1)>>1 computed in CNT_W+1 bits.
//   - cycles wraps from all-ones to 0 with no flag.
// TESTING
//  1. Reset, run=1, N=4 -> clk_en every 4 cycles; clk_div 1100 repeating; cycles +1 per 4.
//  2. N=5 -> clk_div 11100 repeating; phase 0,1,2,3,4,0.
//  3. Running N=4, div_req with div_val=6 at phase 1 -> div_ack with next clk_en;
//     following periods 6 cycles, clk_div 111000.
//  4. div_req with div_val=1, then div_val=0 -> div_err pulses; N and the clk_div pattern
//     are unchanged; no div_ack.
//  5. run=0 at phase 1 of N=4 -> current period completes, then clk_div stays 0,
//     state IDLE. Reassert run -> clk_en 1 cycle later.
//  6. rst_n low at phase 2 with a ratio pending -> all outputs 0 immediately;
//     N=DEFAULT_DIV after release; no div_ack. Also preload cycles near 2^CYC_W-1
//     and check the wrap to 0.

Source files
------------

// File: rtl/ixc_phase_divider_if.sv
// rtl/ixc_phase_divider_if.sv - run/ratio handshake and divided-clock outputs of the phase divider
interface ixc_phase_divider_if #(
    parameter int CNT_W = 8,
    parameter int CYC_W = 32
) ();
    logic             run;
    logic             div_req;
    logic [CNT_W-1:0] div_val;
    logic             div_ack;
    logic             div_err;
    logic             clk_en;
    logic             clk_div;
    logic [CNT_W-1:0] phase;
    logic [CYC_W-1:0] cycles;

    modport master (
        output run, div_req, div_val,
        input  div_ack, div_err, clk_en, clk_div, phase, cycles
    );

    modport slave (
        input  run, div_req, div_val,
        output div_ack, div_err, clk_en, clk_div, phase, cycles
    );
endinterface

// File: rtl/ixc_phase_divider.sv
// rtl/ixc_phase_divider.sv - glitch-free programmable clock divider with boundary-aligned ratio changes
module ixc_phase_divider #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int CYC_W       = 32
) (
    input  logic                 phi1,
    input  logic                 rst_n,
    ixc_phase_divider_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    localparam logic [CNT_W-1:0] ONE     = 1;
    localparam logic [CNT_W-1:0] TWO     = 2;
    localparam logic [CNT_W:0]   ONE_X   = 1;
    localparam logic [CYC_W-1:0] CYC_ONE = 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic             div_q, div_d;
    logic             en_q, en_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic             valid_req;
    logic             bad_req;
    logic             boundary;
    logic [CNT_W:0]   half;
    logic [CNT_W:0]   phase_inc;

    assign valid_req = bus.div_req && (bus.div_val >= TWO);
    assign bad_req   = bus.div_req && (bus.div_val <  TWO);
    assign boundary  = (phase_q == n_q - ONE);
    // high time is ceil(N/2); the extra bit keeps N=2^CNT_W-1 from overflowing
    assign half      = ({1'b0, n_q} + ONE_X) >> 1;
    assign phase_inc = {1'b0, phase_q} + ONE_X;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        pend_d   = pend_q;
        phase_d  = phase_q;
        cycles_d = cycles_q;
        div_d    = div_q;
        en_d     = 1'b0;
        ack_d    = 1'b0;
        err_d    = bad_req;

        case (state_q)
            IDLE: begin
                phase_d = '0;
                div_d   = 1'b0;
                if (valid_req) begin
                    n_d   = bus.div_val;
                    ack_d = 1'b1;
                end
                if (bus.run) begin
                    state_d = RUN;
                    div_d   = 1'b1;
                    en_d    = 1'b1;
                end
            end
            default: begin
                if (!boundary) begin
                    phase_d = phase_q + ONE;
                    div_d   = (phase_inc < half);
                    if (valid_req) begin
                        pend_d  = bus.div_val;
                        state_d = PEND;
                    end
                end else begin
                    cycles_d = cycles_q + CYC_ONE;
                    phase_d  = '0;
                    if (state_q == PEND) begin
                        n_d   = pend_q;
                        ack_d = 1'b1;
                    end
                    state_d = bus.run ? RUN : IDLE;
                    // a request landing on the boundary waits for the next one,
                    // unless we are stopping and there is no next boundary
                    if (valid_req) begin
                        if (bus.run) begin
                            pend_d  = bus.div_val;
                            state_d = PEND;
                        end else begin
                            n_d   = bus.div_val;
                            ack_d = 1'b1;
                        end
                    end
                    div_d = bus.run;
                    en_d  = bus.run;
                end
            end
        endcase
    end

    always_ff @(posedge phi1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            n_q      <= CNT_W'(DEFAULT_DIV);
            pend_q   <= '0;
            phase_q  <= '0;
            cycles_q <= '0;
            div_q    <= 1'b0;
            en_q     <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            pend_q   <= pend_d;
            phase_q  <= phase_d;
            cycles_q <= cycles_d;
            div_q    <= div_d;
            en_q     <= en_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign bus.div_ack = ack_q;
    assign bus.div_err = err_q;
    assign bus.clk_en  = en_q;
    assign bus.clk_div = div_q;
    assign bus.phase   = phase_q;
    assign bus.cycles  = cycles_q;
endmodule
